mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage of the 5-stage core. It sits between EX and WB. It accepts one instruction at a time from EX and performs loads and stores over a req/gnt/rvalid data-memory interface. It aligns and sign-extends load data and hands a registered pipeline bus plus a bypass bus to WB and the forwarding logic. Non-memory instructions pass through with 1-cycle latency.

Parameters:
XLEN, 32, datapath/address width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
bus_i  in  core::pipeline_bus_t  instruction from EX; rd, rd_res, pipeline_stall carried through
valid_i  in  1  bus_i and the mem fields below are valid this cycle
ready_o  out  1  stage can accept (to EX)
ld_i  in  1  instruction is a load
st_i  in  1  instruction is a store
funct3_i  in  3  RV32I load/store funct3
addr_i  in  XLEN  effective byte address
st_data_i  in  XLEN  store data (rs2)
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1=write
dmem_addr_o  out  XLEN  word-aligned address (bits[1:0]=0)
dmem_wdata_o  out  XLEN  lane-replicated write data
dmem_be_o  out  4  byte enables
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  XLEN  read data word
wb_bus_o  out  core::pipeline_bus_t  registered bus to WB
wb_valid_o  out  1  wb_bus_o valid (1-cycle pulse per instruction)
misalign_o  out  1  misaligned/illegal access flag, qualified by wb_valid_o
mem_bp_o  out  core::bypass_bus_t  forwarding: rd=wb_bus_o.rd_res, rd_addr=wb_bus_o.rd when wb_valid_o else 0

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset: state IDLE; all outputs 0, except ready_o=1; wb_bus_o all-zero. Mid-transaction reset abandons the access: dmem_req_o drops immediately and any later gnt/rvalid is ignored.
- FSM states: IDLE, REQ, WAIT_R.
- ready_o=1 only in IDLE. Accept = valid_i & ready_o. WB never backpressures.
- IDLE, accept of a non-memory op (ld_i=st_i=0): next cycle wb_bus_o=bus_i and wb_valid_o=1; stay IDLE.
- IDLE, accept of a memory op: capture addr, funct3, data, bus and ld/st.
- Misaligned or illegal captured access: no memory request; next cycle wb_valid_o=1, misalign_o=1, wb_bus_o.rd forced 0. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0. Illegal means load funct3 ∈{011,110,111} or store funct3 ≥011.
- Aligned access: go to REQ.
- REQ: dmem_req_o=1 with stable addr/we/be/wdata until gnt.
  - gnt on a store: next cycle wb_valid_o=1; return to IDLE.
  - gnt on a load without rvalid: go to WAIT_R.
  - gnt and rvalid in the same cycle: complete the load directly.
- WAIT_R: dmem_req_o=0. On rvalid, next cycle wb_valid_o=1 with wb_bus_o.rd_res = extracted load data; return to IDLE.
- rvalid in IDLE or REQ-without-gnt: ignored.
- Store lanes, with o=addr[1:0]:
  - SB: be=0001<<o, wdata={4{data[7:0]}}.
  - SH: be=0011<<(2·addr[1]), wdata={2{data[15:0]}}.
  - SW: be=1111, wdata=data.
  - Loads drive be=1111, we=0.
- Load extraction, selecting the byte/half by offset o:
  - LB: sign-extend byte o.
  - LBU: zero-extend byte o.
  - LH: sign-extend half addr[1].
  - LHU: zero-extend half addr[1].
  - LW: the whole word.
- Latency (accept to wb_valid_o):
  - non-memory op: 1 cycle.
  - store: 2 + gnt wait.
  - load: 2 + gnt wait + rvalid wait.
- wb_bus_o holds its last value when wb_valid_o=0. wb_bus_o.pipeline_stall is copied from the captured bus.

Test Plan:
- Reset mid-load (rst asserted in WAIT_R), then rvalid with 0xFFFFFFFF → no wb_valid_o; outputs 0; ready_o=1 after rst drops.
- Non-mem op, bus_i.rd=5, rd_res=0x1234, valid_i=1 → next cycle wb_valid_o=1, mem_bp_o.rd_addr=5, mem_bp_o.rd=0x1234.
- SB, addr=0x1003, data=0xAB, gnt 2 cycles after req → dmem_addr_o=0x1000, be=1000, wdata=0xABABABAB held until gnt; wb_valid_o one cycle after gnt.
- LB, addr=0x2002, rdata=0x00800000 → rd_res=0xFFFFFF80. LBU, same rdata → 0x00000080. LH, addr=0x2002, rdata=0x80010000 → 0xFFFF8001.
- LW, addr=0x3001 → no dmem_req_o; next cycle wb_valid_o=1, misalign_o=1, rd=0.
- Load with gnt and rvalid in the same cycle, rdata=0xDEADBEEF → wb_valid_o next cycle with rd_res=0xDEADBEEF; back-to-back accept the cycle after.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; loads/stores over req/gnt/rvalid,
// load alignment/extension, registered WB bus plus forwarding bus.
package core;
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] rd_res;
      logic        pipeline_stall;
   } pipeline_bus_t;
   typedef struct packed {
      logic [31:0] rd;
      logic [4:0]  rd_addr;
   } bypass_bus_t;
endpackage

module mem_stage #(
   parameter int XLEN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  core::pipeline_bus_t bus_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic               ld_i,
   input  logic               st_i,
   input  logic [2:0]         funct3_i,
   input  logic [XLEN-1:0]    addr_i,
   input  logic [XLEN-1:0]    st_data_i,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic [XLEN-1:0]    dmem_addr_o,
   output logic [XLEN-1:0]    dmem_wdata_o,
   output logic [3:0]         dmem_be_o,
   input  logic               dmem_gnt_i,
   input  logic               dmem_rvalid_i,
   input  logic [XLEN-1:0]    dmem_rdata_i,
   output core::pipeline_bus_t wb_bus_o,
   output logic               wb_valid_o,
   output logic               misalign_o,
   output core::bypass_bus_t  mem_bp_o
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
   state_t              state_q;
   logic [XLEN-1:0]     addr_q, data_q;
   logic [2:0]          f3_q;
   logic                st_q, wb_valid_q, mis_q;
   core::pipeline_bus_t bus_q, wb_bus_q, ld_bus_d, bad_bus_d;
   logic                accept, bad, req;
   logic [XLEN-1:0]     sh, ld_res;
   logic [15:0]         half;
   logic [3:0]          be;
   logic [XLEN-1:0]     wdata;

   assign ready_o = state_q == IDLE;
   assign accept  = valid_i & ready_o;
   assign bad = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) ||
                (ld_i && (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11)) ||
                (st_i && funct3_i >= 3'b011);
   // extraction works on the word as returned, selecting lanes by the captured offset
   assign sh     = dmem_rdata_i >> {addr_q[1:0], 3'b000};
   assign half   = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
   assign ld_res = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                   f3_q == 3'b100 ? {24'b0, sh[7:0]} :
                   f3_q == 3'b001 ? {{16{half[15]}}, half} :
                   f3_q == 3'b101 ? {16'b0, half} : dmem_rdata_i;
   assign be    = !st_q ? 4'b1111 :
                  f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                  f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wdata = f3_q[1:0] == 2'b00 ? {4{data_q[7:0]}} :
                  f3_q[1:0] == 2'b01 ? {2{data_q[15:0]}} : data_q;

   always_comb begin
      ld_bus_d        = bus_q;
      ld_bus_d.rd_res = ld_res;
      bad_bus_d       = bus_i;
      bad_bus_d.rd    = '0;
   end

   assign req          = state_q == REQ;
   assign dmem_req_o   = req;
   assign dmem_we_o    = req & st_q;
   assign dmem_addr_o  = req ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign dmem_be_o    = req ? be : 4'b0000;
   assign dmem_wdata_o = req ? wdata : '0;
   assign wb_bus_o     = wb_bus_q;
   assign wb_valid_o   = wb_valid_q;
   assign misalign_o   = mis_q;
   assign mem_bp_o.rd      = wb_valid_q ? wb_bus_q.rd_res : '0;
   assign mem_bp_o.rd_addr = wb_valid_q ? wb_bus_q.rd : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         f3_q       <= '0;
         st_q       <= 1'b0;
         bus_q      <= '0;
         wb_bus_q   <= '0;
         wb_valid_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         mis_q      <= 1'b0;
         case (state_q)
            IDLE: if (accept) begin
               if (!ld_i && !st_i) begin
                  wb_bus_q   <= bus_i;
                  wb_valid_q <= 1'b1;
               end else if (bad) begin
                  wb_bus_q   <= bad_bus_d;
                  wb_valid_q <= 1'b1;
                  mis_q      <= 1'b1;
               end else begin
                  addr_q  <= addr_i;
                  data_q  <= st_data_i;
                  f3_q    <= funct3_i;
                  st_q    <= st_i;
                  bus_q   <= bus_i;
                  state_q <= REQ;
               end
            end
            REQ: if (dmem_gnt_i) begin
               if (st_q || dmem_rvalid_i) begin
                  wb_bus_q   <= st_q ? bus_q : ld_bus_d;
                  wb_valid_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  state_q <= WAIT_R;
               end
            end
            WAIT_R: if (dmem_rvalid_i) begin
               wb_bus_q   <= ld_bus_d;
               wb_valid_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage; expected WB results are queued
// at issue and checked when wb_valid_o pulses.
module tb_mem_stage;
   logic                clk = 1'b0;
   logic                rst = 1'b1;
   core::pipeline_bus_t bus_i = '0;
   logic                valid_i = 1'b0, ld_i = 1'b0, st_i = 1'b0;
   logic [2:0]          funct3_i = '0;
   logic [31:0]         addr_i = '0, st_data_i = '0;
   logic                ready_o, dmem_req_o, dmem_we_o;
   logic [31:0]         dmem_addr_o, dmem_wdata_o;
   logic [3:0]          dmem_be_o;
   logic                dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
   logic [31:0]         dmem_rdata_i = '0;
   core::pipeline_bus_t wb_bus_o;
   logic                wb_valid_o, misalign_o;
   core::bypass_bus_t   mem_bp_o;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] res;
      logic        mis;
      logic        stall;
   } exp_t;
   exp_t sb[$];
   int   n_cmp = 0, n_err = 0;

   mem_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .bus_i(bus_i), .valid_i(valid_i), .ready_o(ready_o),
      .ld_i(ld_i), .st_i(st_i), .funct3_i(funct3_i), .addr_i(addr_i), .st_data_i(st_data_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_bus_o(wb_bus_o),
      .wb_valid_o(wb_valid_o), .misalign_o(misalign_o), .mem_bp_o(mem_bp_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wb_valid_o) begin
         if (sb.size() == 0) chk("stray_wb", 32'(wb_valid_o), 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_rd", 32'(wb_bus_o.rd), 32'(e.rd));
            chk("wb_res", wb_bus_o.rd_res, e.res);
            chk("wb_stall", 32'(wb_bus_o.pipeline_stall), 32'(e.stall));
            chk("misalign", 32'(misalign_o), 32'(e.mis));
            chk("bp_addr", 32'(mem_bp_o.rd_addr), 32'(e.rd));
            chk("bp_rd", mem_bp_o.rd, e.res);
         end
      end
   end

   task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic [31:0] res, input logic stall,
                        input int gdly, input int rdly, input logic [31:0] rdata,
                        input logic [31:0] exp_res, input logic exp_mis,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
      exp_t e;
      chk("ready", 32'(ready_o), 32'd1);
      valid_i = 1'b1; ld_i = ld; st_i = st; funct3_i = f3; addr_i = addr; st_data_i = data;
      bus_i.rd = rd; bus_i.rd_res = res; bus_i.pipeline_stall = stall;
      e.rd = exp_mis ? 5'd0 : rd; e.res = exp_res; e.mis = exp_mis; e.stall = stall;
      sb.push_back(e);
      @(posedge clk); #1;
      valid_i = 1'b0; ld_i = 1'b0; st_i = 1'b0; bus_i = '0;
      if (!(ld | st) || exp_mis) chk("no_req", 32'(dmem_req_o), 32'd0);
      else begin
         for (int i = 0; i <= gdly; i++) begin
            chk("req", 32'(dmem_req_o), 32'd1);
            chk("addr", dmem_addr_o, {addr[31:2], 2'b00});
            chk("we", 32'(dmem_we_o), 32'(st));
            chk("be", 32'(dmem_be_o), 32'(exp_be));
            chk("wdata", dmem_wdata_o, exp_wd);
            if (i == gdly) begin
               dmem_gnt_i = 1'b1;
               if (ld && rdly == 0) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; end
            end else if (ld) begin
               dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
         end
         if (ld && rdly > 0) begin
            for (int i = 1; i < rdly; i++) begin
               chk("wait_noreq", 32'(dmem_req_o), 32'd0);
               chk("wait_nowb", 32'(wb_valid_o), 32'd0);
               @(posedge clk); #1;
            end
            dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
            @(posedge clk); #1;
            dmem_rvalid_i = 1'b0;
         end
      end
      chk("wb_valid", 32'(wb_valid_o), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_wbv", 32'(wb_valid_o), 32'd0);
      chk("rst_bus", 32'(wb_bus_o.rd_res), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      // non-memory op
      do_op(0, 0, 3'b000, 0, 0, 5'd5, 32'h1234, 1'b0, 0, 0, 0, 32'h1234, 0, 4'h0, 0);
      // SB, SH, SW
      do_op(0, 1, 3'b000, 32'h1003, 32'hAB, 5'd0, 32'h77, 1'b1, 2, 0, 0, 32'h77, 0, 4'b1000, 32'hABABABAB);
      do_op(0, 1, 3'b001, 32'h1002, 32'h1234ABCD, 5'd0, 32'h0, 1'b0, 0, 0, 0, 32'h0, 0, 4'b1100, 32'hABCDABCD);
      do_op(0, 1, 3'b010, 32'h1004, 32'hCAFEF00D, 5'd1, 32'h9, 1'b0, 1, 0, 0, 32'h9, 0, 4'b1111, 32'hCAFEF00D);
      // loads
      do_op(1, 0, 3'b000, 32'h2002, 32'h0, 5'd7, 32'h0, 1'b0, 1, 2, 32'h00800000, 32'hFFFFFF80, 0, 4'hF, 32'h0);
      do_op(1, 0, 3'b100, 32'h2002, 32'h0, 5'd8, 32'h0, 1'b0, 0, 1, 32'h00800000, 32'h00000080, 0, 4'hF, 32'h0);
      do_op(1, 0, 3'b001, 32'h2002, 32'h0, 5'd9, 32'h0, 1'b1, 0, 0, 32'h80010000, 32'hFFFF8001, 0, 4'hF, 32'h0);
      do_op(1, 0, 3'b101, 32'h2000, 32'h0, 5'd10, 32'h0, 1'b0, 0, 1, 32'h1234F00D, 32'h0000F00D, 0, 4'hF, 32'h0);
      do_op(1, 0, 3'b010, 32'h4000, 32'h0, 5'd11, 32'h0, 1'b0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4'hF, 32'h0);
      // back-to-back after same-cycle gnt/rvalid load
      do_op(0, 0, 3'b000, 0, 0, 5'd12, 32'h55AA, 1'b0, 0, 0, 0, 32'h55AA, 0, 4'h0, 0);
      // misaligned and illegal
      do_op(1, 0, 3'b010, 32'h3001, 32'h0, 5'd13, 32'h42, 1'b0, 0, 0, 0, 32'h42, 1, 4'h0, 0);
      do_op(0, 1, 3'b001, 32'h1001, 32'h0, 5'd0, 32'h43, 1'b0, 0, 0, 0, 32'h43, 1, 4'h0, 0);
      do_op(1, 0, 3'b011, 32'h3000, 32'h0, 5'd14, 32'h44, 1'b0, 0, 0, 0, 32'h44, 1, 4'h0, 0);
      do_op(0, 1, 3'b100, 32'h3000, 32'h0, 5'd0, 32'h45, 1'b0, 0, 0, 0, 32'h45, 1, 4'h0, 0);
      // stray rvalid in IDLE
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0;
      chk("idle_rvalid", 32'(wb_valid_o), 32'd0);
      // reset in WAIT_R abandons the load
      valid_i = 1'b1; ld_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h5000; bus_i.rd = 5'd3;
      @(posedge clk); #1;
      valid_i = 1'b0; ld_i = 1'b0; bus_i = '0; dmem_gnt_i = 1'b1;
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0;
      chk("waitr_noreq", 32'(dmem_req_o), 32'd0);
      chk("waitr_busy", 32'(ready_o), 32'd0);
      rst = 1'b1; #1;
      chk("arst_req", 32'(dmem_req_o), 32'd0);
      chk("arst_ready", 32'(ready_o), 32'd1);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0;
      chk("post_rst_wbv", 32'(wb_valid_o), 32'd0);
      chk("post_rst_ready", 32'(ready_o), 32'd1);
      chk("post_rst_bp", mem_bp_o.rd, 32'd0);
      chk("post_rst_addr", dmem_addr_o, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
